lsu_ctrl: RTL and testbench

LSU_CTRL -- requirements
Module: lsu_ctrl

---
 rtl/lsu_ctrl_if.sv | 60 ++++++
 rtl/lsu_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_ctrl_if.sv
// -----------------------------------------------------------------------------
// lsu_ctrl_if -- bundle of all handshake/bus signals of the load/store unit.
//
// Groups:
//   req_*  : pipeline -> LSU request (valid/ready), with size, sign and data
//   mem_*  : LSU -> memory request (req/gnt) and memory -> LSU response
//            (rvalid/rdata)
//   rsp_*  : LSU -> pipeline completion pulse, load data and error flag
//
// Handshakes:
//   req : a request transfers on a rising edge where req_valid && req_ready.
//   mem : mem_req with its attributes stays stable until the edge where
//         mem_gnt=1. The single mem_rvalid that follows carries read data
//         or acknowledges a write.
//   rsp : rsp_valid is a one-cycle pulse. It has no back-pressure.
//
// Modports:
//   slave  : the LSU itself
//   master : the surrounding pipeline plus memory (testbench side)
// -----------------------------------------------------------------------------
interface lsu_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic              req_unsigned;
    logic [2:0]        req_mode;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic              mem_rvalid;
    logic [31:0]       mem_rdata;

    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport slave (
        input  req_valid, req_we, req_unsigned, req_mode, req_addr, req_wdata,
        output req_ready,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata,
        output rsp_valid, rsp_rdata, rsp_err
    );

    modport master (
        output req_valid, req_we, req_unsigned, req_mode, req_addr, req_wdata,
        input  req_ready,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata,
        input  rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_ctrl -- single-outstanding load/store unit controller.
//
// The controller accepts one request from the pipeline. It issues one
// word-aligned memory access with byte enables and replicated store data.
// It waits for the grant and then the read-data/ack. It returns a
// one-cycle rsp_valid pulse with the lane-extracted, sign- or
// zero-extended load data. A request with an illegal size is answered
// with rsp_err and does not touch memory.
//
// Ports:
//   clk        : clock, all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   bus        : lsu_ctrl_if.slave (request, memory and response signals)
//   dbg_state  : current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 DONE)
//
// Configuration macro LSU_MISALIGN_CHECK_EN:
//   defined   : a misaligned half or word is answered with rsp_err and no
//               memory access.
//   undefined : misaligned addresses are aligned naturally by clearing the
//               low address bits.
//
// Latency (no stalls): the request is accepted at cycle T, mem_req is
// high at T+1, the data phase is at T+2 and rsp_valid is high at T+3.
// The error path gives rsp_valid at T+1.
// -----------------------------------------------------------------------------
module lsu_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    lsu_ctrl_if.slave  bus,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // ------------------------------------------------------------------
    // Request decode (combinational, only meaningful in IDLE)
    // ------------------------------------------------------------------
    logic        mode_ok;
    logic        misalign;
    logic        req_err;
    logic [1:0]  eff_off;
    logic [3:0]  be_dec;
    logic [31:0] wdata_dec;
    logic        accept;

    always_comb begin
        mode_ok = (bus.req_mode == 3'b001) || (bus.req_mode == 3'b010) ||
                  (bus.req_mode == 3'b100);
`ifdef LSU_MISALIGN_CHECK_EN
        misalign = (bus.req_mode[1] & bus.req_addr[0]) |
                   (bus.req_mode[2] & (|bus.req_addr[1:0]));
`else
        misalign = 1'b0;
`endif
        req_err = !mode_ok || misalign;

        // The effective byte offset clears the low bits that the access
        // size does not allow. This gives natural alignment when the
        // misalign check is not built in.
        eff_off   = 2'b00;
        be_dec    = 4'b0000;
        wdata_dec = 32'h0;
        case (bus.req_mode)
            3'b001: begin
                eff_off   = bus.req_addr[1:0];
                be_dec    = 4'b0001 << bus.req_addr[1:0];
                wdata_dec = {4{bus.req_wdata[7:0]}};
            end
            3'b010: begin
                eff_off   = {bus.req_addr[1], 1'b0};
                be_dec    = 4'b0011 << {bus.req_addr[1], 1'b0};
                wdata_dec = {2{bus.req_wdata[15:0]}};
            end
            3'b100: begin
                eff_off   = 2'b00;
                be_dec    = 4'b1111;
                wdata_dec = bus.req_wdata;
            end
            default: begin
                eff_off   = 2'b00;
                be_dec    = 4'b0000;
                wdata_dec = 32'h0;
            end
        endcase
    end

    assign accept = (state == IDLE) && bus.req_valid;

    // ------------------------------------------------------------------
    // Captured request attributes
    // ------------------------------------------------------------------
    logic              we_q;
    logic              uns_q;
    logic [2:0]        mode_q;
    logic [1:0]        off_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_be_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;

    // Memory attributes are loaded only for legal requests. A rejected
    // request therefore leaves the memory bus untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            uns_q       <= 1'b0;
            mode_q      <= 3'b000;
            off_q       <= 2'b00;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0;
        end else if (accept && !req_err) begin
            we_q        <= bus.req_we;
            uns_q       <= bus.req_unsigned;
            mode_q      <= bus.req_mode;
            off_q       <= eff_off;
            mem_we_q    <= bus.req_we;
            mem_addr_q  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            mem_be_q    <= be_dec;
            mem_wdata_q <= wdata_dec;
        end
    end

    // ------------------------------------------------------------------
    // Load data extraction
    // ------------------------------------------------------------------
    logic [31:0] rdata_shift;
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_result;

    always_comb begin
        rdata_shift = bus.mem_rdata >> {off_q, 3'b000};
        lane_byte   = rdata_shift[7:0];
        lane_half   = rdata_shift[15:0];
        load_result = bus.mem_rdata;
        case (mode_q)
            3'b001:  load_result = {{24{~uns_q & lane_byte[7]}}, lane_byte};
            3'b010:  load_result = {{16{~uns_q & lane_half[15]}}, lane_half};
            default: load_result = bus.mem_rdata;
        endcase
        if (we_q) begin
            load_result = 32'h0;
        end
    end

    // The response registers change only on entry to DONE. They hold
    // their value in between.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else if (accept && req_err) begin
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b1;
        end else if ((state == WAIT) && bus.mem_rvalid) begin
            rsp_rdata_q <= load_result;
            rsp_err_q   <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // mem_rvalid is sampled only in WAIT. A response that arrives after a
    // reset has abandoned an access is therefore dropped.
    always_comb begin
        state_nxt     = state;
        bus.req_ready = 1'b0;
        bus.mem_req   = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_nxt = req_err ? DONE : REQ;
                end
            end
            REQ: begin
                bus.mem_req = 1'b1;
                if (bus.mem_gnt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                bus.rsp_valid = 1'b1;
                state_nxt     = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_lsu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_ctrl -- directed testbench for lsu_ctrl.
//
// run_access drives one request and acts as the memory. It grants after
// a chosen number of mem_req cycles and returns rvalid in the cycle after
// the grant. It records what it observes. Each test_* task compares these
// observations with hand-computed values.
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

    logic       clk;
    logic       rst_n;
    logic [1:0] dbg_state;

    int checks;
    int errors;

    lsu_ctrl_if #(.ADDR_W(32)) bus ();

    lsu_ctrl #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observations from the last run_access.
    logic        obs_saw_req;
    logic        obs_we;
    logic [31:0] obs_addr;
    logic [3:0]  obs_be;
    logic [31:0] obs_wdata;
    logic [31:0] obs_rdata;
    logic        obs_err;
    logic        obs_stable;
    int          obs_lat;
    int          obs_pulses;
    int          obs_req_cyc;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_access(input logic we, input logic uns, input logic [2:0] mode,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int gnt_delay);
        logic granted_prev;
        logic granted_now;
        int   cyc;
        obs_saw_req = 1'b0; obs_we = 1'b0; obs_addr = '0; obs_be = '0; obs_wdata = '0;
        obs_rdata = '0; obs_err = 1'b0; obs_stable = 1'b1;
        obs_lat = -1; obs_pulses = 0; obs_req_cyc = 0;
        granted_prev = 1'b0;
        cyc = 0;
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_unsigned = uns;
        bus.req_mode     = mode;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.mem_gnt      = 1'b0;
        bus.mem_rvalid   = 1'b0;
        bus.mem_rdata    = rdata;
        for (int i = 0; i < 40; i++) begin
            step();
            cyc++;
            bus.req_valid  = 1'b0;
            bus.mem_gnt    = 1'b0;
            bus.mem_rvalid = 1'b0;
            granted_now    = 1'b0;
            if (bus.rsp_valid) begin
                obs_pulses++;
                if (obs_lat < 0) begin
                    obs_lat   = cyc;
                    obs_rdata = bus.rsp_rdata;
                    obs_err   = bus.rsp_err;
                end
            end
            if (bus.mem_req) begin
                if (!obs_saw_req) begin
                    obs_we    = bus.mem_we;
                    obs_addr  = bus.mem_addr;
                    obs_be    = bus.mem_be;
                    obs_wdata = bus.mem_wdata;
                end else if (bus.mem_we !== obs_we || bus.mem_addr !== obs_addr ||
                             bus.mem_be !== obs_be || bus.mem_wdata !== obs_wdata) begin
                    obs_stable = 1'b0;
                end
                obs_saw_req = 1'b1;
                obs_req_cyc++;
                if (obs_req_cyc > gnt_delay) begin
                    bus.mem_gnt = 1'b1;
                    granted_now = 1'b1;
                end
            end
            if (granted_prev) begin
                bus.mem_rvalid = 1'b1;
            end
            granted_prev = granted_now;
            if (obs_lat >= 0 && cyc >= obs_lat + 2) break;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_unsigned = 1'b0;
        bus.req_mode = 3'b000; bus.req_addr = '0; bus.req_wdata = '0;
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
        step();
        step();
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %0b want 0", bus.mem_req); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %0b want 0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
        checks++; if (bus.mem_be !== 4'h0) begin errors++; $display("FAIL reset_mem_be got %b want 0000", bus.mem_be); end
        checks++; if (bus.mem_wdata !== 32'h0) begin errors++; $display("FAIL reset_mem_wdata got %h want 0", bus.mem_wdata); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b want 0", bus.rsp_valid); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got %h want 0", bus.rsp_rdata); end
        checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL reset_rsp_err got %0b want 0", bus.rsp_err); end
        rst_n = 1'b1;
        step();
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b want 1", bus.req_ready); end
    endtask

    task automatic test_store_byte();
        run_access(1'b1, 1'b0, 3'b001, 32'h0000_1003, 32'h0000_00AB, 32'h5555_5555, 0);
        checks++; if (obs_addr !== 32'h0000_1000) begin errors++; $display("FAIL sb_addr got %h want 00001000", obs_addr); end
        checks++; if (obs_be !== 4'b1000) begin errors++; $display("FAIL sb_be got %b want 1000", obs_be); end
        checks++; if (obs_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata got %h want abababab", obs_wdata); end
        checks++; if (obs_we !== 1'b1) begin errors++; $display("FAIL sb_we got %0b want 1", obs_we); end
        checks++; if (obs_lat !== 3) begin errors++; $display("FAIL sb_latency got %0d want 3", obs_lat); end
        checks++; if (obs_rdata !== 32'h0) begin errors++; $display("FAIL sb_rdata got %h want 0", obs_rdata); end
        checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL sb_err got %0b want 0", obs_err); end
        checks++; if (obs_pulses !== 1) begin errors++; $display("FAIL sb_pulses got %0d want 1", obs_pulses); end
    endtask

    task automatic test_store_half();
        run_access(1'b1, 1'b0, 3'b010, 32'h0000_5002, 32'h1234_5678, 32'h0, 0);
        checks++; if (obs_addr !== 32'h0000_5000) begin errors++; $display("FAIL sh_addr got %h want 00005000", obs_addr); end
        checks++; if (obs_be !== 4'b1100) begin errors++; $display("FAIL sh_be got %b want 1100", obs_be); end
        checks++; if (obs_wdata !== 32'h5678_5678) begin errors++; $display("FAIL sh_wdata got %h want 56785678", obs_wdata); end
    endtask

    task automatic test_load_half();
        run_access(1'b0, 1'b0, 3'b010, 32'h0000_2002, 32'h0, 32'h8001_1234, 0);
        checks++; if (obs_be !== 4'b1100) begin errors++; $display("FAIL lh_be got %b want 1100", obs_be); end
        checks++; if (obs_we !== 1'b0) begin errors++; $display("FAIL lh_we got %0b want 0", obs_we); end
        checks++; if (obs_rdata !== 32'hFFFF_8001) begin errors++; $display("FAIL lh_signed got %h want ffff8001", obs_rdata); end
        checks++; if (obs_lat !== 3) begin errors++; $display("FAIL lh_latency got %0d want 3", obs_lat); end
        run_access(1'b0, 1'b1, 3'b010, 32'h0000_2002, 32'h0, 32'h8001_1234, 0);
        checks++; if (obs_rdata !== 32'h0000_8001) begin errors++; $display("FAIL lhu_unsigned got %h want 00008001", obs_rdata); end
        // The response holds after the pulse until the next completion.
        checks++; if (bus.rsp_rdata !== 32'h0000_8001) begin errors++; $display("FAIL lhu_hold got %h want 00008001", bus.rsp_rdata); end
    endtask

    task automatic test_load_byte();
        run_access(1'b0, 1'b0, 3'b001, 32'h0000_4001, 32'h0, 32'h1122_8344, 0);
        checks++; if (obs_be !== 4'b0010) begin errors++; $display("FAIL lb_be got %b want 0010", obs_be); end
        checks++; if (obs_rdata !== 32'hFFFF_FF83) begin errors++; $display("FAIL lb_signed got %h want ffffff83", obs_rdata); end
        run_access(1'b0, 1'b1, 3'b001, 32'h0000_4002, 32'h0, 32'h1122_8344, 0);
        checks++; if (obs_rdata !== 32'h0000_0022) begin errors++; $display("FAIL lbu_lane2 got %h want 00000022", obs_rdata); end
    endtask

    task automatic test_gnt_delay();
        run_access(1'b0, 1'b0, 3'b100, 32'h0000_3000, 32'h0, 32'hCAFE_F00D, 5);
        checks++; if (obs_req_cyc !== 6) begin errors++; $display("FAIL gd_req_cycles got %0d want 6", obs_req_cyc); end
        checks++; if (obs_stable !== 1'b1) begin errors++; $display("FAIL gd_stable got %0b want 1", obs_stable); end
        checks++; if (obs_addr !== 32'h0000_3000) begin errors++; $display("FAIL gd_addr got %h want 00003000", obs_addr); end
        checks++; if (obs_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL gd_rdata got %h want cafef00d", obs_rdata); end
        checks++; if (obs_lat !== 8) begin errors++; $display("FAIL gd_latency got %0d want 8", obs_lat); end
        checks++; if (obs_pulses !== 1) begin errors++; $display("FAIL gd_pulses got %0d want 1", obs_pulses); end
    endtask

    task automatic test_misalign();
        run_access(1'b0, 1'b0, 3'b100, 32'h0000_3002, 32'h0, 32'h1357_9BDF, 0);
`ifdef LSU_MISALIGN_CHECK_EN
        checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL ma_err got %0b want 1", obs_err); end
        checks++; if (obs_lat !== 1) begin errors++; $display("FAIL ma_latency got %0d want 1", obs_lat); end
        checks++; if (obs_saw_req !== 1'b0) begin errors++; $display("FAIL ma_mem_req got %0b want 0", obs_saw_req); end
`else
        checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL ma_err got %0b want 0", obs_err); end
        checks++; if (obs_addr !== 32'h0000_3000) begin errors++; $display("FAIL ma_addr got %h want 00003000", obs_addr); end
        checks++; if (obs_rdata !== 32'h1357_9BDF) begin errors++; $display("FAIL ma_rdata got %h want 13579bdf", obs_rdata); end
        checks++; if (obs_lat !== 3) begin errors++; $display("FAIL ma_latency got %0d want 3", obs_lat); end
`endif
    endtask

    task automatic test_bad_mode();
        run_access(1'b0, 1'b0, 3'b011, 32'h0000_7000, 32'h0, 32'h2468_ACE0, 0);
        checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL bm011_err got %0b want 1", obs_err); end
        checks++; if (obs_saw_req !== 1'b0) begin errors++; $display("FAIL bm011_mem_req got %0b want 0", obs_saw_req); end
        checks++; if (obs_lat !== 1) begin errors++; $display("FAIL bm011_latency got %0d want 1", obs_lat); end
        run_access(1'b1, 1'b0, 3'b000, 32'h0000_7004, 32'h0, 32'h0, 0);
        checks++; if (obs_err !== 1'b1) begin errors++; $display("FAIL bm000_err got %0b want 1", obs_err); end
        checks++; if (obs_saw_req !== 1'b0) begin errors++; $display("FAIL bm000_mem_req got %0b want 0", obs_saw_req); end
        // A legal access afterwards clears the error flag.
        run_access(1'b0, 1'b0, 3'b100, 32'h0000_7008, 32'h0, 32'h0BAD_BEEF, 0);
        checks++; if (obs_err !== 1'b0) begin errors++; $display("FAIL bm_recover_err got %0b want 0", obs_err); end
    endtask

    task automatic test_reset_in_wait();
        int pulses;
        bus.req_valid    = 1'b1;
        bus.req_we       = 1'b0;
        bus.req_unsigned = 1'b0;
        bus.req_mode     = 3'b100;
        bus.req_addr     = 32'h0000_6000;
        bus.mem_gnt      = 1'b0;
        bus.mem_rvalid   = 1'b0;
        step();
        bus.req_valid = 1'b0;
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL rw_mem_req got %0b want 1", bus.mem_req); end
        bus.mem_gnt = 1'b1;
        step();
        bus.mem_gnt = 1'b0;
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rw_wait_mem_req got %0b want 0", bus.mem_req); end
        rst_n = 1'b0;
        #2;
        checks++; if (bus.mem_addr !== 32'h0) begin errors++; $display("FAIL rw_async_addr got %h want 0", bus.mem_addr); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rw_async_rdata got %h want 0", bus.rsp_rdata); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rw_async_ready got %0b want 1", bus.req_ready); end
        rst_n = 1'b1;
        step();
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hDEAD_BEEF;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            bus.mem_rvalid = 1'b0;
            if (bus.rsp_valid) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rw_stale_pulses got %0d want 0", pulses); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin errors++; $display("FAIL rw_stale_rdata got %h want 0", bus.rsp_rdata); end
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rw_idle_ready got %0b want 1", bus.req_ready); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_store_byte();
        test_store_half();
        test_load_half();
        test_load_byte();
        test_gnt_delay();
        test_misalign();
        test_bad_mode();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
